// File: rtl/count_sampler_pkg.sv
// Shared types and constants for count_sampler.
// The sample delta field exists only when COUNT_SAMPLER_DELTA_EN is defined.
package count_sampler_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] cnt1;
      logic [CNT_W-1:0] cnt2;
`ifdef COUNT_SAMPLER_DELTA_EN
      logic [CNT_W-1:0] delta;
`endif
   } sample_t;

endpackage

// File: rtl/count_sampler_fifo.sv
// Power-of-two FIFO for count_sampler samples; a push while full is accepted
// only when a pop happens in the same cycle. Empty reads return zero.
module count_sampler_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/count_sampler.sv
// Decimating sampler of upstream counter values into a FIFO, ending a run at THRESHOLD.
// Define COUNT_SAMPLER_DELTA_EN to add the out_delta port and stored delta field.
module count_sampler
   import count_sampler_pkg::*;
#(
   parameter int unsigned      DEPTH     = 4,
   parameter int unsigned      DECIM     = 4,
   parameter logic [CNT_W-1:0] THRESHOLD = 8'd208
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CNT_W-1:0]       cnt1_in,
   input  logic [CNT_W-1:0]       cnt2_in,
   input  logic                   start,
   input  logic                   clear,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       out_cnt1,
   output logic [CNT_W-1:0]       out_cnt2,
`ifdef COUNT_SAMPLER_DELTA_EN
   output logic [CNT_W-1:0]       out_delta,
`endif
   output logic [$clog2(DEPTH):0] level,
   output logic                   done,
   output logic                   overflow
);

   localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

   state_t     state;
   logic [7:0] dcnt;
   logic       strobe;
   logic       hit;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   sample_t    din;
   sample_t    dout;

   assign strobe    = (state == RUN) && (dcnt == '0);
   assign hit       = strobe && (cnt2_in == THRESHOLD);
   // clear outranks any same-cycle push or pop
   assign push      = strobe && !clear;
   assign pop       = out_valid && out_ready && !clear;
   assign out_valid = !empty;
   assign out_cnt1  = dout.cnt1;
   assign out_cnt2  = dout.cnt2;
`ifdef COUNT_SAMPLER_DELTA_EN
   assign out_delta = dout.delta;
`endif

   always_comb begin
      din      = '0;
      din.cnt1 = cnt1_in;
      din.cnt2 = cnt2_in;
`ifdef COUNT_SAMPLER_DELTA_EN
      din.delta = cnt2_in - cnt1_in;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         dcnt     <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         dcnt     <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (strobe && full && !pop) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  dcnt  <= '0;
               end
            end
            RUN: begin
               if (hit) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  dcnt <= (dcnt == DECIM_LAST) ? '0 : dcnt + 8'd1;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

   count_sampler_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(sample_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_count_sampler.sv
// Scoreboard bench for count_sampler (DEPTH=4, DECIM=4, THRESHOLD=208).
// Honours COUNT_SAMPLER_DELTA_EN when defined for the whole build.
module tb_count_sampler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cnt1_in = '0;
   logic [7:0] cnt2_in = '0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_cnt1;
   logic [7:0] out_cnt2;
   logic [2:0] level;
   logic       done;
   logic       overflow;
   logic [7:0] dlt;

`ifdef COUNT_SAMPLER_DELTA_EN
   localparam bit DELTA_ON = 1'b1;
   logic [7:0] out_delta;
   assign dlt = out_delta;
`else
   localparam bit DELTA_ON = 1'b0;
   assign dlt = '0;
`endif

   logic [23:0] exp_q [$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   count_sampler #(
      .DEPTH     (4),
      .DECIM     (4),
      .THRESHOLD (8'd208)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt1_in   (cnt1_in),
      .cnt2_in   (cnt2_in),
      .start     (start),
      .clear     (clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cnt1  (out_cnt1),
      .out_cnt2  (out_cnt2),
`ifdef COUNT_SAMPLER_DELTA_EN
      .out_delta (out_delta),
`endif
      .level     (level),
      .done      (done),
      .overflow  (overflow)
   );

   function automatic logic [23:0] mk(input logic [7:0] c1, input logic [7:0] c2);
      logic [7:0] d;
      d = DELTA_ON ? 8'(c2 - c1) : 8'h00;
      return {c1, c2, d};
   endfunction

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear = 1'b1; start = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d required 0", level); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      n_cmp++; if ({out_cnt1, out_cnt2} !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h required 0000", {out_cnt1, out_cnt2}); end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [23:0] e;
      int npop = 0;
      for (int c = 0; c <= 22; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(c); cnt2_in = 8'(c); start = (c == 5); out_ready = 1'b1;
         if (c >= 6 && (c - 6) % 4 == 0) exp_q.push_back(mk(8'(c), 8'(c)));
         @(negedge clk);
         if (c == 6) begin n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_level_c6: got %0d required 0", level); end end
         if (c == 7) begin n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL basic_level_c7: got %0d required 1", level); end end
         if (c == 8) begin n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_level_c8: got %0d required 0", level); end end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_pop: got %h required no sample", {out_cnt1, out_cnt2, dlt}); end
            else begin
               e = exp_q.pop_front(); npop++;
               if ({out_cnt1, out_cnt2, dlt} !== e) begin n_err++; $display("FAIL basic_pop: got %h required %h", {out_cnt1, out_cnt2, dlt}, e); end
            end
         end
      end
      n_cmp++; if (npop !== 4) begin n_err++; $display("FAIL basic_pop_count: got %0d required 4", npop); end
      pulse_clear();
   endtask

   task automatic test_threshold();
      logic [23:0] e;
      int npop = 0;
      for (int c = 0; c <= 25; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(250 + c); cnt2_in = 8'(197 + c); start = (c == 2) || (c == 15); out_ready = 1'b1;
         if (c >= 3 && c <= 11 && (c - 3) % 4 == 0) exp_q.push_back(mk(8'(250 + c), 8'(197 + c)));
         @(negedge clk);
         if (c == 11) begin n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL thr_done_c11: got %b required 0", done); end end
         if (c == 12) begin n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL thr_done_c12: got %b required 1", done); end end
         if (c == 20) begin n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL thr_level_c20: got %0d required 0", level); end end
         if (c == 25) begin n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL thr_done_sticky: got %b required 1", done); end end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL thr_pop: got %h required no sample", {out_cnt1, out_cnt2, dlt}); end
            else begin
               e = exp_q.pop_front(); npop++;
               if ({out_cnt1, out_cnt2, dlt} !== e) begin n_err++; $display("FAIL thr_pop: got %h required %h", {out_cnt1, out_cnt2, dlt}, e); end
            end
         end
      end
      n_cmp++; if (npop !== 3) begin n_err++; $display("FAIL thr_pop_count: got %0d required 3", npop); end
      pulse_clear();
   endtask

   task automatic test_full_push_pop();
      logic [23:0] e;
      for (int c = 0; c <= 20; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(247 + c); cnt2_in = 8'(1 + c); start = (c == 2); out_ready = (c == 19);
         if (c >= 3 && (c - 3) % 4 == 0) exp_q.push_back(mk(8'(247 + c), 8'(1 + c)));
         @(negedge clk);
         if (c == 16 || c == 20) begin
            n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fpp_level_c%0d: got %0d required 4", c, level); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow_c%0d: got %b required 0", c, overflow); end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL fpp_pop: got %h required no sample", {out_cnt1, out_cnt2, dlt}); end
            else begin
               e = exp_q.pop_front();
               if ({out_cnt1, out_cnt2, dlt} !== e) begin n_err++; $display("FAIL fpp_pop: got %h required %h", {out_cnt1, out_cnt2, dlt}, e); end
            end
         end
      end
      pulse_clear();
   endtask

   task automatic test_overflow();
      logic [23:0] e;
      int npop = 0;
      for (int c = 0; c <= 32; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(175 + c); cnt2_in = 8'(185 + c); start = (c == 2); out_ready = (c >= 24);
         if (c >= 3 && c <= 15 && (c - 3) % 4 == 0) exp_q.push_back(mk(8'(175 + c), 8'(185 + c)));
         @(negedge clk);
         if (c == 16) begin n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flag_c16: got %b required 0", overflow); end end
         if (c == 20) begin n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag_c20: got %b required 1", overflow); end end
         if (c == 24) begin
            n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d required 4", level); end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b required 1", done); end
            n_cmp++; if (out_cnt1 !== 8'd178) begin n_err++; $display("FAIL ovf_head: got %0d required 178", out_cnt1); end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL ovf_pop: got %h required no sample", {out_cnt1, out_cnt2, dlt}); end
            else begin
               e = exp_q.pop_front(); npop++;
               if ({out_cnt1, out_cnt2, dlt} !== e) begin n_err++; $display("FAIL ovf_pop: got %h required %h", {out_cnt1, out_cnt2, dlt}, e); end
            end
         end
      end
      n_cmp++; if (npop !== 4) begin n_err++; $display("FAIL ovf_pop_count: got %0d required 4", npop); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
   endtask

   // Entered from DONE with overflow still set; no clear in between.
   task automatic test_clear();
      for (int c = 0; c <= 18; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(c); cnt2_in = 8'(c); out_ready = 1'b0;
         start = (c == 2) || (c == 6) || (c == 13);
         clear = (c == 6) || (c == 14);
         @(negedge clk);
         if (c == 5) begin
            n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL clr_done_ignore_start: got level %0d required 0", level); end
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL clr_done_before: got %b required 1", done); end
         end
         if (c == 7) begin
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_done_after: got %b required 0", done); end
            n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_overflow_after: got %b required 0", overflow); end
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid_after: got %b required 0", out_valid); end
         end
         if (c == 12 || c == 15 || c == 18) begin
            n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL clr_level_c%0d: got %0d required 0", c, level); end
         end
      end
      clear = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk); #1;
         cnt1_in = 8'(40 + c); cnt2_in = 8'(c); start = (c == 1); out_ready = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL mid_level_before: got %0d required 3", level); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_async: got %b required 0", out_valid); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_level_async: got %0d required 0", level); end
      n_cmp++; if (out_cnt1 !== 8'd0) begin n_err++; $display("FAIL mid_cnt1_async: got %0d required 0", out_cnt1); end
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_after: got %b required 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_threshold();
      test_full_push_pop();
      test_overflow();
      test_clear();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
